// File: rtl/isp_agc.sv
// isp_agc - frame-level automatic gain controller for the ISP digital-gain stage.
//
// Collects the sum and count of active pixels seen after the gain stage. At
// every vsync rising edge the finished frame is judged against target with a
// dead band of +/-HYST. The 4.4 gain word is then stepped up or down by
// GAIN_STEP within [GAIN_MIN, GAIN_MAX]. A new gain is only applied on a
// vsync falling edge, so it always takes effect during blanking.
//
// Optional build macro ISP_AGC_MANUAL_EN adds the manual_en / manual_gain
// override ports. When it is undefined the controller is purely automatic.
module isp_agc #(
    parameter int         BITS      = 8,
    parameter int         WIDTH     = 1280,
    parameter int         HEIGHT    = 960,
    parameter int         HYST      = 8,
    parameter logic [7:0] GAIN_INIT = 8'h10,
    parameter logic [7:0] GAIN_MIN  = 8'h10,
    parameter logic [7:0] GAIN_MAX  = 8'hFF,
    parameter int         GAIN_STEP = 1,
    localparam int        N         = WIDTH * HEIGHT,
    localparam int        CNTW      = $clog2(N + 1),
    localparam int        SUMW      = BITS + CNTW
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [BITS-1:0] target,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_raw,
`ifdef ISP_AGC_MANUAL_EN
    input  logic            manual_en,
    input  logic [7:0]      manual_gain,
`endif
    output logic [7:0]      gain_out,
    output logic [SUMW-1:0] frame_sum,
    output logic [1:0]      lvl,
    output logic            frame_err
);

    // Width used for target +/- HYST before scaling by N.
    localparam int TW = BITS + 2;
    // Width of the scaled thresholds; wide enough that nothing wraps.
    localparam int PW = TW + CNTW;

    localparam logic [CNTW-1:0] N_C       = CNTW'(N);
    localparam logic [CNTW-1:0] CNT_MAX_C = {CNTW{1'b1}};
    localparam logic [TW-1:0]   HYST_C    = TW'(HYST);
    localparam logic [8:0]      STEP9_C   = 9'(GAIN_STEP);
    localparam logic [7:0]      STEP8_C   = 8'(GAIN_STEP);

    localparam logic [1:0] LVL_IN_BAND = 2'b00;
    localparam logic [1:0] LVL_DARK    = 2'b01;
    localparam logic [1:0] LVL_BRIGHT  = 2'b10;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_EVAL = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic              vsync_d_r;
    logic              armed_r;
    logic [SUMW-1:0]   acc_r;
    logic [CNTW-1:0]   cnt_r;
    logic [SUMW-1:0]   s_r;
    logic [CNTW-1:0]   c_r;
    logic [SUMW-1:0]   frame_sum_r;
    logic [1:0]        lvl_r;
    logic              frame_err_r;
    logic [7:0]        gain_r;
    logic [7:0]        next_gain_r;
    logic              pending_r;

    logic              boundary_s;
    logic              vsync_fall_s;
    logic              manual_s;
    logic [7:0]        manual_gain_s;
    logic [TW-1:0]     t_lo_s;
    logic [TW-1:0]     t_hi_s;
    logic [PW-1:0]     lo_s;
    logic [PW-1:0]     hi_s;
    logic [PW-1:0]     s_ext_s;
    logic [1:0]        lvl_nxt_s;
    logic [8:0]        gain_up_s;
    logic [7:0]        gain_step_s;

    assign boundary_s   = in_vsync & ~vsync_d_r;
    assign vsync_fall_s = ~in_vsync & vsync_d_r;

`ifdef ISP_AGC_MANUAL_EN
    assign manual_s      = manual_en;
    assign manual_gain_s = manual_gain;
`else
    assign manual_s      = 1'b0;
    assign manual_gain_s = GAIN_INIT;
`endif

    // FSM state register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_ACC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: ACC waits for an armed boundary, EVAL skips STEP on a bad pixel count.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_ACC: begin
                if (boundary_s && armed_r) begin
                    state_nxt_s = ST_EVAL;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_EVAL: begin
                if (c_r == N_C) begin
                    state_nxt_s = ST_STEP;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            ST_STEP: state_nxt_s = ST_ACC;
            default: state_nxt_s = ST_ACC;
        endcase
    end

    // Dead-band thresholds scaled by N, and the classification of the latched sum.
    always_comb begin
        t_hi_s = {2'b00, target} + HYST_C;
        if ({2'b00, target} > HYST_C) begin
            t_lo_s = {2'b00, target} - HYST_C;
        end else begin
            t_lo_s = {TW{1'b0}};
        end
        lo_s    = PW'(t_lo_s) * PW'(N_C);
        hi_s    = PW'(t_hi_s) * PW'(N_C);
        s_ext_s = PW'(s_r);
        if (s_ext_s < lo_s) begin
            lvl_nxt_s = LVL_DARK;
        end else if (s_ext_s > hi_s) begin
            lvl_nxt_s = LVL_BRIGHT;
        end else begin
            lvl_nxt_s = LVL_IN_BAND;
        end
    end

    // Candidate gain for the current lvl, clamped to the allowed range.
    always_comb begin
        gain_up_s = {1'b0, gain_r} + STEP9_C;
        case (lvl_r)
            LVL_DARK: begin
                if (gain_up_s > {1'b0, GAIN_MAX}) begin
                    gain_step_s = GAIN_MAX;
                end else begin
                    gain_step_s = gain_up_s[7:0];
                end
            end
            LVL_BRIGHT: begin
                if ({1'b0, gain_r} < ({1'b0, GAIN_MIN} + STEP9_C)) begin
                    gain_step_s = GAIN_MIN;
                end else begin
                    gain_step_s = gain_r - STEP8_C;
                end
            end
            default: gain_step_s = gain_r;
        endcase
    end

    // Statistics: accumulate active pixels, latch on an armed boundary, publish in EVAL.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_r   <= 1'b0;
            armed_r     <= 1'b0;
            acc_r       <= {SUMW{1'b0}};
            cnt_r       <= {CNTW{1'b0}};
            s_r         <= {SUMW{1'b0}};
            c_r         <= {CNTW{1'b0}};
            frame_sum_r <= {SUMW{1'b0}};
            lvl_r       <= LVL_IN_BAND;
            frame_err_r <= 1'b0;
        end else begin
            vsync_d_r   <= in_vsync;
            frame_err_r <= 1'b0;
            if (boundary_s) begin
                // Every boundary restarts the frame; only an armed one in ACC is evaluated.
                acc_r <= {SUMW{1'b0}};
                cnt_r <= {CNTW{1'b0}};
                if (!armed_r) begin
                    armed_r <= 1'b1;
                end else if (state_r == ST_ACC) begin
                    s_r <= acc_r;
                    c_r <= cnt_r;
                end
            end else if (in_href && !in_vsync) begin
                acc_r <= acc_r + SUMW'(in_raw);
                if (cnt_r != CNT_MAX_C) begin
                    cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
                end
            end
            if (state_r == ST_EVAL) begin
                if (c_r == N_C) begin
                    frame_sum_r <= s_r;
                    lvl_r       <= lvl_nxt_s;
                end else begin
                    frame_err_r <= 1'b1;
                end
            end
        end
    end

    // Gain control: queue a step from STEP, apply it on a later vsync fall, or take the manual value.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            gain_r      <= GAIN_INIT;
            next_gain_r <= GAIN_INIT;
            pending_r   <= 1'b0;
        end else begin
            if (manual_s) begin
                pending_r <= 1'b0;
                if (vsync_fall_s) begin
                    gain_r <= manual_gain_s;
                end
            end else if (!enable) begin
                pending_r <= 1'b0;
            end else if (state_r == ST_STEP) begin
                next_gain_r <= gain_step_s;
                pending_r   <= 1'b1;
            end else if (pending_r && vsync_fall_s) begin
                gain_r    <= next_gain_r;
                pending_r <= 1'b0;
            end
        end
    end

    assign gain_out  = gain_r;
    assign frame_sum = frame_sum_r;
    assign lvl       = lvl_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_isp_agc.sv
// tb_isp_agc - directed bench for isp_agc with a 4x2 frame, target 100, HYST 8.
// Thresholds: lo = 92*8 = 736, hi = 108*8 = 864.
module tb_isp_agc;

    logic        pclk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  target;
    logic        in_href;
    logic        in_vsync;
    logic [7:0]  in_raw;
`ifdef ISP_AGC_MANUAL_EN
    logic        manual_en;
    logic [7:0]  manual_gain;
`endif
    logic [7:0]  gain_out;
    logic [11:0] frame_sum;
    logic [1:0]  lvl;
    logic        frame_err;

    int n_checks;
    int n_pass;
    int err_seen;

    isp_agc #(
        .WIDTH  (4),
        .HEIGHT (2)
    ) dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .enable      (enable),
        .target      (target),
        .in_href     (in_href),
        .in_vsync    (in_vsync),
        .in_raw      (in_raw),
`ifdef ISP_AGC_MANUAL_EN
        .manual_en   (manual_en),
        .manual_gain (manual_gain),
`endif
        .gain_out    (gain_out),
        .frame_sum   (frame_sum),
        .lvl         (lvl),
        .frame_err   (frame_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Count frame_err cycles, sampled away from the active edge.
    always @(negedge pclk) begin
        if (frame_err === 1'b1) err_seen = err_seen + 1;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_pixels(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) begin
            @(negedge pclk);
            in_href = 1'b1;
            in_raw  = v;
        end
        @(negedge pclk);
        in_href = 1'b0;
        in_raw  = 8'd0;
    endtask

    task automatic vsync_pulse(input int len);
        @(negedge pclk);
        err_seen = 0;
        in_vsync = 1'b1;
        repeat (len) @(negedge pclk);
        in_vsync = 1'b0;
        repeat (5) @(negedge pclk);
    endtask

    task automatic do_frame(input int n, input logic [7:0] v, input int len);
        send_pixels(n, v);
        vsync_pulse(len);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        err_seen = 0;
        rst_n    = 1'b0;
        enable   = 1'b1;
        target   = 8'd100;
        in_href  = 1'b0;
        in_vsync = 1'b0;
        in_raw   = 8'd0;
`ifdef ISP_AGC_MANUAL_EN
        manual_en   = 1'b0;
        manual_gain = 8'h00;
`endif
        repeat (3) @(negedge pclk);
        check_eq("rst_gain", 32'(gain_out), 32'h10);
        check_eq("rst_sum", 32'(frame_sum), 32'd0);
        check_eq("rst_lvl", 32'(lvl), 32'd0);
        check_eq("rst_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;

        // First boundary only arms the controller.
        do_frame(8, 8'd50, 6);
        check_eq("first_err", 32'(err_seen), 32'd0);
        check_eq("first_sum", 32'(frame_sum), 32'd0);
        check_eq("first_gain", 32'(gain_out), 32'h10);

        // Dark frame: 8*50 = 400 < 736.
        do_frame(8, 8'd50, 6);
        check_eq("dark_sum", 32'(frame_sum), 32'd400);
        check_eq("dark_lvl", 32'(lvl), 32'd1);
        check_eq("dark_gain", 32'(gain_out), 32'h11);

        // In band: 800.
        do_frame(8, 8'd100, 6);
        check_eq("band_sum", 32'(frame_sum), 32'd800);
        check_eq("band_lvl", 32'(lvl), 32'd0);
        check_eq("band_gain", 32'(gain_out), 32'h11);

        // Bright: 1600 > 864, steps down then clamps at GAIN_MIN.
        do_frame(8, 8'd200, 6);
        check_eq("bright_sum", 32'(frame_sum), 32'd1600);
        check_eq("bright_lvl", 32'(lvl), 32'd2);
        check_eq("bright_gain", 32'(gain_out), 32'h10);
        do_frame(8, 8'd200, 6);
        check_eq("clamp_lvl", 32'(lvl), 32'd2);
        check_eq("clamp_gain", 32'(gain_out), 32'h10);

        // Short frame: one frame_err cycle, outputs held.
        do_frame(7, 8'd50, 6);
        check_eq("short_err", 32'(err_seen), 32'd1);
        check_eq("short_sum", 32'(frame_sum), 32'd1600);
        check_eq("short_lvl", 32'(lvl), 32'd2);
        check_eq("short_gain", 32'(gain_out), 32'h10);

        // 2-cycle vsync: evaluation happens but gain waits for the next fall.
        do_frame(8, 8'd50, 2);
        check_eq("pulse2_sum", 32'(frame_sum), 32'd400);
        check_eq("pulse2_lvl", 32'(lvl), 32'd1);
        check_eq("pulse2_gain", 32'(gain_out), 32'h10);
        do_frame(7, 8'd50, 6);
        check_eq("defer_err", 32'(err_seen), 32'd1);
        check_eq("defer_gain", 32'(gain_out), 32'h11);

        // Ramp to 0x14 with dark frames.
        for (int i = 0; i < 3; i++) do_frame(8, 8'd50, 6);
        check_eq("ramp_gain", 32'(gain_out), 32'h14);

        // Mid-frame reset returns everything to reset values at once.
        send_pixels(4, 8'd50);
        @(negedge pclk);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_gain", 32'(gain_out), 32'h10);
        check_eq("mrst_sum", 32'(frame_sum), 32'd0);
        check_eq("mrst_lvl", 32'(lvl), 32'd0);
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        do_frame(4, 8'd50, 6);
        check_eq("unarmed_err", 32'(err_seen), 32'd0);
        check_eq("unarmed_sum", 32'(frame_sum), 32'd0);
        check_eq("unarmed_gain", 32'(gain_out), 32'h10);
        do_frame(8, 8'd50, 6);
        check_eq("rearm_sum", 32'(frame_sum), 32'd400);
        check_eq("rearm_gain", 32'(gain_out), 32'h11);

        // enable=0 freezes the gain while lvl keeps updating.
        do_frame(8, 8'd100, 6);
        enable = 1'b0;
        do_frame(8, 8'd50, 6);
        check_eq("frozen_lvl", 32'(lvl), 32'd1);
        check_eq("frozen_gain", 32'(gain_out), 32'h11);

        // Dropping enable while an update is pending cancels it.
        enable = 1'b1;
        do_frame(8, 8'd50, 2);
        enable = 1'b0;
        do_frame(7, 8'd50, 6);
        check_eq("cancel_gain", 32'(gain_out), 32'h11);
        enable = 1'b1;

`ifdef ISP_AGC_MANUAL_EN
        manual_en   = 1'b1;
        manual_gain = 8'h30;
        do_frame(8, 8'd100, 6);
        check_eq("manual_gain", 32'(gain_out), 32'h30);
        manual_en = 1'b0;
        do_frame(8, 8'd50, 6);
        check_eq("resume_gain", 32'(gain_out), 32'h31);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
